// File: rtl/snn_image_loader.sv
// Image feeder for snn_core: unpacks 98 UART bytes LSB-first into the input RAM,
// starts the core and reports its digit. Optional inter-byte timeout: IMG_TIMEOUT_EN.
module snn_image_loader #(
  parameter int unsigned NUM_PIXELS  = 784,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned TIMEOUT_CYC = 5_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_data,
  output logic              core_start,
  input  logic              core_done,
  input  logic [3:0]        core_digit,
  output logic [3:0]        digit_out,
  output logic              result_vld,
  output logic              busy,
  output logic              rx_err
);

  localparam int unsigned CNT_W = $clog2(NUM_PIXELS + 1);

  typedef enum logic [2:0] {
    S_RECV,
    S_SHIFT,
    S_START,
    S_RUN,
    S_REPORT
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  pix_q, pix_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        sh_q, sh_d;
  logic [7:0]        pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        digit_q, digit_d;
  logic              err_q, err_d;
  logic              timeout;

`ifdef IMG_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYC + 1);
  logic [IDLE_W-1:0] idle_q;

  assign timeout = (state_q == S_RECV) && (pix_q != '0) && !rx_rdy &&
                   (idle_q == IDLE_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= '0;
    end else if (state_q != S_RECV || rx_rdy || pix_q == '0 || timeout) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_q + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pix_d      = pix_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    addr_d     = addr_q;
    digit_d    = digit_q;
    err_d      = err_q;

    case (state_q)
      S_RECV: begin
        if (rx_rdy) begin
          sh_d    = rx_data;
          bit_d   = '0;
          state_d = S_SHIFT;
          if (pix_q == '0) err_d = 1'b0;
        end else if (timeout) begin
          pix_d = '0;
          err_d = 1'b1;
        end
      end
      S_SHIFT: begin
        sh_d   = {1'b0, sh_q[7:1]};
        pix_d  = pix_q + 1'b1;
        bit_d  = bit_q + 1'b1;
        addr_d = ADDR_W'(pix_q);
        if (bit_q == 3'd7) begin
          if (pix_q == CNT_W'(NUM_PIXELS - 1)) begin
            state_d    = S_START;
            pend_vld_d = 1'b0;
          end else if (pend_vld_q) begin
            sh_d       = pend_q;
            pend_d     = rx_data;
            pend_vld_d = rx_rdy;
          end else if (rx_rdy) begin
            // A byte landing on the exit edge would pass through pending and be
            // consumed next; loading it directly is equivalent and gap-free.
            sh_d = rx_data;
          end else begin
            state_d = S_RECV;
          end
        end else if (rx_rdy) begin
          if (pend_vld_q) begin
            err_d = 1'b1;
          end else begin
            pend_d     = rx_data;
            pend_vld_d = 1'b1;
          end
        end
      end
      S_START: begin
        pix_d      = '0;
        pend_vld_d = 1'b0;
        state_d    = S_RUN;
        if (rx_rdy) err_d = 1'b1;
      end
      S_RUN: begin
        if (rx_rdy) err_d = 1'b1;
        if (core_done) begin
          digit_d = core_digit;
          state_d = S_REPORT;
        end
      end
      S_REPORT: begin
        if (rx_rdy) err_d = 1'b1;
        state_d = S_RECV;
      end
      default: state_d = S_RECV;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RECV;
      pix_q      <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      addr_q     <= '0;
      digit_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pix_q      <= pix_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      addr_q     <= addr_d;
      digit_q    <= digit_d;
      err_q      <= err_d;
    end
  end

  assign ram_we     = (state_q == S_SHIFT);
  assign ram_addr   = ram_we ? ADDR_W'(pix_q) : addr_q;
  assign ram_data   = ram_we & sh_q[0];
  assign core_start = (state_q == S_START);
  assign result_vld = (state_q == S_REPORT);
  assign busy       = (state_q == S_START) || (state_q == S_RUN) || (state_q == S_REPORT);
  assign digit_out  = digit_q;
  assign rx_err     = err_q;

endmodule

// File: tb/tb_snn_image_loader.sv
// Directed/randomized bench for snn_image_loader; reference image model is a byte list
// unpacked arithmetically into pixel expectations.
module tb_snn_image_loader;

  localparam int unsigned NPIX = 784;
  localparam int unsigned NBYTES = NPIX / 8;
  localparam int unsigned AW = 10;
  localparam int unsigned TO = 100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_rdy = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic          ram_data;
  logic          core_start;
  logic          core_done = 1'b0;
  logic [3:0]    core_digit = '0;
  logic [3:0]    digit_out;
  logic          result_vld;
  logic          busy;
  logic          rx_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_addr[$];
  int wr_data[$];
  int wr_cyc[$];
  int start_cyc[$];
  int vld_cnt = 0;
  logic [7:0] img[$];

  snn_image_loader #(
    .NUM_PIXELS (NPIX),
    .ADDR_W     (AW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_rdy    (rx_rdy),
    .rx_data   (rx_data),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .core_start(core_start),
    .core_done (core_done),
    .core_digit(core_digit),
    .digit_out (digit_out),
    .result_vld(result_vld),
    .busy      (busy),
    .rx_err    (rx_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      wr_addr.push_back(int'(ram_addr));
      wr_data.push_back(int'(ram_data));
      wr_cyc.push_back(cyc);
    end
    if (core_start === 1'b1) start_cyc.push_back(cyc);
    if (result_vld === 1'b1) vld_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_rdy  = 1'b1;
    rx_data = b;
    tick();
    rx_rdy  = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    start_cyc.delete();
  endtask

  task automatic new_image(input int fixed, input logic [7:0] val);
    img.delete();
    for (int i = 0; i < NBYTES; i++)
      img.push_back(fixed != 0 ? val : 8'($urandom_range(0, 255)));
  endtask

  // Pixel k of the image must be written at address k with bit (k%8) of byte k/8.
  task automatic check_writes(input string tag, input int nbytes);
    int bad = 0;
    int exp_bit;
    check({tag, "_wcount"}, wr_addr.size(), nbytes * 8);
    for (int i = 0; i < wr_addr.size() && i < nbytes * 8; i++) begin
      exp_bit = int'((img[i / 8] >> (i % 8)) & 8'd1);
      if (wr_addr[i] != i || wr_data[i] != exp_bit) bad++;
    end
    check({tag, "_wdata"}, bad, 0);
  endtask

  task automatic check_contiguous(input string tag, input int first, input int n, input int c0);
    int bad = 0;
    for (int i = first; i < first + n; i++)
      if (i >= wr_cyc.size() || wr_cyc[i] != c0 + (i - first)) bad++;
    check(tag, bad, 0);
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (start_cyc.size() == 0 && n < 40) begin
      tick();
      n++;
    end
    check(tag, start_cyc.size(), 1);
  endtask

  task automatic run_core(input string tag, input logic [3:0] d, input int hold);
    int v0 = vld_cnt;
    core_digit = d;
    core_done  = 1'b1;
    tick(hold);
    core_done  = 1'b0;
    tick(3);
    check({tag, "_digit"}, digit_out, d);
    check({tag, "_vld"}, vld_cnt - v0, 1);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int d0;
    int last;
    int nw;
    logic [3:0] dg;

    // reset state
    tick(3);
    check("rst_outs", {ram_we, ram_data, core_start, result_vld, busy, rx_err}, 0);
    check("rst_digit_addr", {digit_out, ram_addr}, 0);
    rst_n = 1'b1;
    tick(2);

    // 1: 98 bytes of 0xA5, 20 cycles apart
    clear_log();
    new_image(1, 8'hA5);
    d0 = cyc;
    last = cyc;
    for (int i = 0; i < NBYTES; i++) begin
      last = cyc;
      send(img[i]);
      if (i != NBYTES - 1) tick(19);
    end
    wait_start("t1_start_seen");
    check("t1_first_wr_lat", wr_cyc.size() > 0 ? wr_cyc[0] - d0 : -1, 1);
    check("t1_start_lat", start_cyc.size() > 0 ? start_cyc[0] - last : -1, 9);
    check_writes("t1", NBYTES);
    tick(5);
    check("t1_start_single", start_cyc.size(), 1);
    check("t1_busy", busy, 1);
    check("t1_rx_err", rx_err, 0);

    // 2: core result digit 7
    check("t2_no_vld_yet", vld_cnt, 0);
    core_digit = 4'd7;
    core_done  = 1'b1;
    tick();
    core_done  = 1'b0;
    check("t2_digit", digit_out, 7);
    check("t2_vld_hi", result_vld, 1);
    check("t2_busy_report", busy, 1);
    tick();
    check("t2_vld_lo", result_vld, 0);
    check("t2_busy_lo", busy, 0);
    check("t2_vld_count", vld_cnt, 1);

    // 3: back-to-back pair, then an overrunning triple
    clear_log();
    new_image(0, 8'h00);
    d0 = cyc;
    send(img[0]);
    send(img[1]);
    tick(20);
    check_contiguous("t3_pair_nogap", 0, 16, d0 + 1);
    check("t3_pair_err", rx_err, 0);
    d0 = cyc;
    send(img[2]);
    send(img[3]);
    send(8'($urandom_range(0, 255)));
    tick(20);
    check("t3_triple_err", rx_err, 1);
    check_contiguous("t3_triple_nogap", 16, 16, d0 + 1);
    check_writes("t3_partial", 4);
    for (int i = 4; i < NBYTES; i++) begin
      send(img[i]);
      tick(11);
    end
    wait_start("t3_start_seen");
    check_writes("t3", NBYTES);
    check("t3_err_sticky", rx_err, 1);
    dg = 4'($urandom_range(0, 15));
    run_core("t3_core_level", dg, 3);

    // 4: byte during RUN is dropped and flagged; next image clears the flag
    clear_log();
    new_image(0, 8'h00);
    send(img[0]);
    check("t4_err_cleared", rx_err, 0);
    tick(9);
    for (int i = 1; i < NBYTES; i++) begin
      send(img[i]);
      tick(9);
    end
    wait_start("t4_start_seen");
    tick(3);
    check_writes("t4", NBYTES);
    nw = wr_addr.size();
    send(8'hFF);
    tick(2);
    check("t4_run_err", rx_err, 1);
    check("t4_run_nowrite", wr_addr.size(), nw);
    check("t4_run_busy", busy, 1);
    dg = 4'($urandom_range(0, 15));
    run_core("t4_core", dg, 1);
    send(8'($urandom_range(0, 255)));
    check("t4_next_err_clr", rx_err, 0);
    tick(9);

    // 5: reset mid-load, then a full image from address 0
    for (int i = 1; i < 40; i++) begin
      send(8'($urandom_range(0, 255)));
      if (i != 39) tick(9);
    end
    tick(3);
    rst_n = 1'b0;
    #2;
    check("t5_rst_outs", {ram_we, ram_data, core_start, result_vld, busy, rx_err}, 0);
    check("t5_rst_digit_addr", {digit_out, ram_addr}, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    clear_log();
    new_image(0, 8'h00);
    for (int i = 0; i < NBYTES; i++) begin
      send(img[i]);
      tick(9);
    end
    wait_start("t5_start_seen");
    check_writes("t5", NBYTES);
    dg = 4'($urandom_range(0, 15));
    run_core("t5_core", dg, 1);

`ifdef IMG_TIMEOUT_EN
    // 6: ten bytes then idle past the timeout
    clear_log();
    for (int i = 0; i < 10; i++) begin
      last = cyc;
      send(8'($urandom_range(0, 255)));
      if (i != 9) tick(9);
    end
    while (cyc < last + 108) tick();
    check("t6_err_before", rx_err, 0);
    tick();
    check("t6_err_timeout", rx_err, 1);
    clear_log();
    new_image(0, 8'h00);
    send(img[0]);
    tick(10);
    check_writes("t6_restart", 1);
    check("t6_err_clr", rx_err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
